spi_transfer_ctrl: RTL

SPI_TRANSFER_CTRL -- requirements
Module: spi_transfer_ctrl

---
 rtl/spi_transfer_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/spi_transfer_ctrl.sv
// SPI master transfer controller: 8-bit, MSB first, CPHA=0.
// It is driven by AXI-style register write strobes and exposes control, status and data readback.
module spi_transfer_ctrl (
  input  logic        FCLK_CLK0,
  input  logic        reset,
  input  logic [31:0] i_data_to_registers,
  input  logic        i_wr_controll_reg,
  input  logic        i_wr_data_reg,
  output logic [31:0] o_controll_reg,
  output logic [31:0] o_status_reg,
  output logic [31:0] o_data_reg,
  output logic        o_sclk,
  output logic        o_mosi,
  input  logic        i_miso,
  output logic        o_cs_n
);

  typedef enum logic [2:0] {StIdle, StSetup, StLead, StTrail, StFinish} state_e;

  state_e     r_state, w_state_next;
  logic       r_cpol, r_cs_hold;
  logic [7:0] r_div, r_tx, r_shift, r_rx_shift, r_rx, r_cnt;
  logic [2:0] r_bit;
  logic       r_done, r_overrun, r_mosi, r_cs_n;

  logic [7:0] w_h;
  logic       w_phase_end, w_idle, w_ctrl_wr_idle, w_start;

  assign w_h            = (r_div == 8'd0) ? 8'd1 : r_div;
  assign w_phase_end    = (r_cnt == w_h - 8'd1);
  assign w_idle         = (r_state == StIdle);
  assign w_ctrl_wr_idle = i_wr_controll_reg && w_idle;
  assign w_start        = w_ctrl_wr_idle && i_data_to_registers[0];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (w_start) w_state_next = StSetup;
      StSetup:  if (w_phase_end) w_state_next = StLead;
      StLead:   if (w_phase_end) w_state_next = StTrail;
      StTrail:  if (w_phase_end) w_state_next = (r_bit == 3'd7) ? StFinish : StLead;
      StFinish: w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge FCLK_CLK0) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cpol     <= 1'b0;
      r_cs_hold  <= 1'b0;
      r_div      <= 8'd0;
      r_tx       <= 8'd0;
      r_shift    <= 8'd0;
      r_rx_shift <= 8'd0;
      r_rx       <= 8'd0;
      r_cnt      <= 8'd0;
      r_bit      <= 3'd0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      r_state <= w_state_next;
      // The divider restarts at every phase boundary, so it never counts past H-1.
      if (w_idle || r_state == StFinish || w_phase_end) r_cnt <= 8'd0;
      else                                              r_cnt <= r_cnt + 8'd1;

      if (!w_idle && (i_wr_controll_reg || i_wr_data_reg)) r_overrun <= 1'b1;
      if (i_wr_data_reg && w_idle) r_tx <= i_data_to_registers[7:0];

      if (w_ctrl_wr_idle) begin
        r_cpol    <= i_data_to_registers[1];
        r_cs_hold <= i_data_to_registers[2];
        r_div     <= i_data_to_registers[15:8];
        if (i_data_to_registers[3]) r_overrun <= 1'b0;
        if (i_data_to_registers[0]) begin
          r_done  <= 1'b0;
          r_cs_n  <= 1'b0;
          r_shift <= r_tx;
          r_mosi  <= r_tx[7];
          r_bit   <= 3'd0;
        end else if (!i_data_to_registers[2]) begin
          r_cs_n <= 1'b1;
        end
      end

      if (r_state == StLead && w_phase_end) begin
        r_rx_shift <= {r_rx_shift[6:0], i_miso};
        r_shift    <= {r_shift[6:0], 1'b0};
        r_mosi     <= r_shift[6];
      end
      if (r_state == StTrail && w_phase_end) r_bit <= r_bit + 3'd1;

      if (r_state == StFinish) begin
        r_rx   <= r_rx_shift;
        r_done <= 1'b1;
        r_cs_n <= ~r_cs_hold;
      end
    end
  end

  assign o_sclk         = (r_state == StLead) ? ~r_cpol : r_cpol;
  assign o_mosi         = r_mosi;
  assign o_cs_n         = r_cs_n;
  assign o_controll_reg = {16'd0, r_div, 4'd0, 1'b0, r_cs_hold, r_cpol, 1'b0};
  assign o_status_reg   = {29'd0, r_overrun, r_done, ~w_idle};
  assign o_data_reg     = {16'd0, r_tx, r_rx};

endmodule
